// File: rtl/uart_wb_bridge_pkg.sv
// Shared constants, state encoding and reply byte selector for the UART-to-Wishbone debug bridge.
package uart_wb_bridge_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] ACK_BYTE  = 8'h2B;
   localparam int         CNT_W     = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WB,
      S_TX,
      S_TX_GAP
   } state_t;

   // MSB-first byte of a 32-bit word, indexed by the byte counter.
   function automatic logic [7:0] reply_byte(input logic [31:0] word, input logic [CNT_W-1:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_wb_bridge.sv
// UART byte stream to Wishbone master: W adr4 dat4 -> 2B, R adr4 -> dat4; optional ADDR/DATA timeout.
// Latency: 2 cycles from rx_ack of last command byte to wb_stb_o; reply starts after wb_ack_i.
// Backpressure: rx bytes held by uart outside IDLE/ADDR/DATA; tx waits on tx_busy; slave stalls via wb_ack_i.
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    state_t           r_state, w_next;
    logic             r_rx_ack;
    logic [7:0]       r_rx_byte;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_we;
    logic [31:0]      r_adr, r_dat, r_reply;
    logic             r_cyc, r_wb_we;
    logic [7:0]       r_tx_data;
    logic             r_tx_wr;
    logic             w_accept, w_shift, w_tx_fire, w_wb_done, w_cnt_last, w_timeout;

    assign w_cnt_last = (r_cnt == CNT_W'(3));

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        w_in_collect;

    assign w_in_collect = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_timeout    = w_in_collect && !r_rx_ack && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || !w_in_collect || r_rx_ack || w_timeout) r_to_cnt <= '0;
        else                                                 r_to_cnt <= r_to_cnt + 32'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_rx_ack && (r_rx_byte == CMD_WRITE || r_rx_byte == CMD_READ)) w_next = S_ADDR;
            S_ADDR:   if (r_rx_ack && w_cnt_last) w_next = r_cmd_we ? S_DATA : S_WB;
                      else if (w_timeout)         w_next = S_IDLE;
            S_DATA:   if (r_rx_ack && w_cnt_last) w_next = S_WB;
                      else if (w_timeout)         w_next = S_IDLE;
            S_WB:     if (r_cyc && wb_ack_i)      w_next = S_TX;
            S_TX:     if (!tx_busy)               w_next = S_TX_GAP;
            S_TX_GAP: w_next = (r_cmd_we || w_cnt_last) ? S_IDLE : S_TX;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept  = rx_avail && !r_rx_ack &&
                    (r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA);
        w_shift   = r_rx_ack && (r_state == S_ADDR || r_state == S_DATA);
        w_tx_fire = (r_state == S_TX) && !tx_busy;
        w_wb_done = r_cyc && wb_ack_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_ack  <= 1'b0;
            r_rx_byte <= '0;
            r_cnt     <= '0;
            r_cmd_we  <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_reply   <= '0;
            r_cyc     <= 1'b0;
            r_wb_we   <= 1'b0;
            r_tx_data <= '0;
            r_tx_wr   <= 1'b0;
        end else begin
            r_rx_ack <= w_accept;
            if (w_accept) r_rx_byte <= rx_data;

            if (r_state == S_IDLE && r_rx_ack) r_cmd_we <= (r_rx_byte == CMD_WRITE);

            if (w_shift) begin
                if (r_state == S_ADDR) r_adr <= {r_adr[23:0], r_rx_byte};
                else                   r_dat <= {r_dat[23:0], r_rx_byte};
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == S_TX_GAP) begin
                r_cnt <= (w_next == S_IDLE) ? '0 : r_cnt + CNT_W'(1);
            end else if (w_timeout) begin
                r_cnt <= '0;
            end

            if (r_state == S_WB && !r_cyc) begin
                r_cyc   <= 1'b1;
                r_wb_we <= r_cmd_we;
            end else if (w_wb_done) begin
                r_cyc   <= 1'b0;
                r_wb_we <= 1'b0;
                if (!r_cmd_we) r_reply <= wb_dat_i;
            end

            r_tx_wr <= w_tx_fire;
            if (w_tx_fire) r_tx_data <= r_cmd_we ? ACK_BYTE : reply_byte(r_reply, r_cnt);
        end
    end

    assign rx_ack   = r_rx_ack;
    assign tx_data  = r_tx_data;
    assign tx_wr    = r_tx_wr;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = r_wb_we;
    assign wb_stb_o = r_cyc;
    assign wb_cyc_o = r_cyc;
    assign busy     = (r_state != S_IDLE);

endmodule
